fetch_stage: RTL

Instruction-fetch stage of the MIPS pipeline, directly upstream of the instruction decoder/control unit. It owns the PC and runs a single-outstanding-request handshake with instruction memory. It holds the IF/ID pipeline register, with stall, flush and branch/jump redirect, and a one-entry skid buffer. It also presents the pre-split fields (opcode, funct, rs, rt, rd, shamt, imm) that decode consumes.

---
 rtl/fetch_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and issues one outstanding request at a time to imem.
// Holds the IF/ID register with a one-entry skid buffer, and splits out the decode fields.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc4,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DROP  = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] drop_addr_q;
    logic        ifid_valid_q;
    logic [31:0] ifid_inst_q;
    logic [31:0] ifid_pc4_q;
    logic [31:0] skid_inst_q;
    logic [31:0] skid_pc4_q;

    logic [31:0] pc_plus4_d;
    logic [31:0] target_pc_d;

    assign pc_plus4_d  = pc_q + 32'd4;
    assign target_pc_d = redirect_pc & ~32'h0000_0003;

    // Request is a pure function of state so the address cannot move while waiting on ready.
    assign imem_req  = !reset && (state_q != S_HOLD);
    assign imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            drop_addr_q  <= 32'h0;
            ifid_valid_q <= 1'b0;
            ifid_inst_q  <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            skid_inst_q  <= 32'h0;
            skid_pc4_q   <= 32'h0;
        end else if (redirect) begin
            pc_q         <= target_pc_d;
            ifid_valid_q <= 1'b0;
            skid_inst_q  <= 32'h0;
            skid_pc4_q   <= 32'h0;
            // A request still in flight must be retired before the new target is fetched.
            if ((state_q != S_HOLD) && !imem_ready) begin
                drop_addr_q <= imem_addr;
                state_q     <= S_DROP;
            end else begin
                state_q <= S_FETCH;
            end
        end else if (flush) begin
            ifid_valid_q <= 1'b0;
            skid_inst_q  <= 32'h0;
            skid_pc4_q   <= 32'h0;
            case (state_q)
                S_HOLD:  state_q <= S_FETCH;
                S_DROP:  if (imem_ready) state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        pc_q <= pc_plus4_d;
                        if (stall) begin
                            skid_inst_q <= imem_rdata;
                            skid_pc4_q  <= pc_plus4_d;
                            state_q     <= S_HOLD;
                        end else begin
                            ifid_valid_q <= 1'b1;
                            ifid_inst_q  <= imem_rdata;
                            ifid_pc4_q   <= pc_plus4_d;
                        end
                    end else if (!stall) begin
                        ifid_valid_q <= 1'b0;
                    end
                end
                S_DROP: begin
                    if (!stall) ifid_valid_q <= 1'b0;
                    if (imem_ready) state_q <= S_FETCH;
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_valid_q <= 1'b1;
                        ifid_inst_q  <= skid_inst_q;
                        ifid_pc4_q   <= skid_pc4_q;
                        skid_inst_q  <= 32'h0;
                        skid_pc4_q   <= 32'h0;
                        state_q      <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // An invalid slot presents as NOP with all derived fields zero.
    assign inst_valid = ifid_valid_q;
    assign inst       = ifid_valid_q ? ifid_inst_q : 32'h0;
    assign inst_pc4   = ifid_valid_q ? ifid_pc4_q : 32'h0;
    assign opcode     = inst[31:26];
    assign rs         = inst[25:21];
    assign rt         = inst[20:16];
    assign rd         = inst[15:11];
    assign shamt      = inst[10:6];
    assign funct      = inst[5:0];
    assign imm        = inst[15:0];

endmodule
